// File: rtl/ir_fetch_if.sv
// Bus bundle for ir_fetch: memory read port, flush control and decoder issue port.
// master = fetch sequencer side, slave = memory/decoder environment side.
interface ir_fetch_if;
    logic        flush;
    logic [15:0] new_ic;
    logic        mem_req;
    logic [15:0] mem_ad;
    logic        mem_ack;
    logic [15:0] mem_dt;
    logic [15:0] w;
    logic [15:0] arg;
    logic        two_word;
    logic        ins_valid;
    logic        ins_ready;
    logic        w_ir;
    logic [15:0] ic;
    logic        alarm;

    modport master (
        input  flush, new_ic, mem_ack, mem_dt, ins_ready,
        output mem_req, mem_ad, w, arg, two_word, ins_valid, w_ir, ic, alarm
    );

    modport slave (
        output flush, new_ic, mem_ack, mem_dt, ins_ready,
        input  mem_req, mem_ad, w, arg, two_word, ins_valid, w_ir, ic, alarm
    );
endinterface

// File: rtl/ir_fetch.sv
// Instruction fetch sequencer: prefetches words at IC into a circular FIFO and issues one- or
// two-word instructions to the decoder. Define IR_FETCH_TIMEOUT_EN for the memory timeout alarm.
module ir_fetch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 15
) (
    input logic        clk_sys,
    input logic        clr_n,
    ir_fetch_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    state_e        state_q, state_d;
    logic [15:0]   buf_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   fa_q, fa_d;
    logic [15:0]   ic_q, ic_d;
    logic          run_q, run_d;
    logic          alarm_q, alarm_d;
`ifdef IR_FETCH_TIMEOUT_EN
    logic [3:0]    tmo_q, tmo_d;
`else
    logic [31:0]   unused_timeout;
    assign unused_timeout = TIMEOUT;
`endif

    logic [15:0]   head, head_nx;
    logic          nonempty, two_word, ins_valid, xfer, push;

    assign head      = buf_q[rd_ptr_q];
    assign head_nx   = buf_q[rd_ptr_q + AW'(1)];
    assign nonempty  = (count_q != '0);
    // IR[13:15] in MSB-first numbering are the three low bits
    assign two_word  = nonempty && (head[2:0] == 3'b000);
    assign ins_valid = nonempty && (!two_word || (count_q >= CW'(2)));
    assign xfer      = ins_valid && bus.ins_ready;
    // Acks are only taken for a request that is live and not being flushed
    assign push      = bus.mem_ack && (state_q == StReq) && !bus.flush;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        fa_d     = fa_q;
        ic_d     = ic_q;
        run_d    = run_q;
        alarm_d  = alarm_q;
`ifdef IR_FETCH_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif

        if (xfer) begin
            rd_ptr_d = rd_ptr_q + (two_word ? AW'(2) : AW'(1));
            ic_d     = ic_q + (two_word ? 16'd2 : 16'd1);
            count_d  = count_d - (two_word ? CW'(2) : CW'(1));
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_d + CW'(1);
            fa_d     = fa_q + 16'd1;
        end

        case (state_q)
            StIdle: begin
                if (run_q && !alarm_q && (count_d < CW'(DEPTH))) begin
                    state_d = StReq;
`ifdef IR_FETCH_TIMEOUT_EN
                    tmo_d   = '0;
`endif
                end
            end
            StReq: begin
                if (push) begin
`ifdef IR_FETCH_TIMEOUT_EN
                    tmo_d = '0;
`endif
                    if (count_d == CW'(DEPTH)) state_d = StIdle;
                end else begin
`ifdef IR_FETCH_TIMEOUT_EN
                    if (tmo_q == 4'(TIMEOUT - 1)) begin
                        alarm_d = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_d = tmo_q + 4'd1;
                    end
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        // A live request is dropped for one cycle so the stale ack cannot be mistaken for new data
        if (bus.flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            fa_d     = bus.new_ic;
            ic_d     = bus.new_ic;
            run_d    = 1'b1;
            alarm_d  = 1'b0;
            state_d  = (state_q == StReq) ? StIdle : StReq;
`ifdef IR_FETCH_TIMEOUT_EN
            tmo_d    = '0;
`endif
        end
    end

    always_ff @(posedge clk_sys or negedge clr_n) begin
        if (!clr_n) begin
            state_q  <= StIdle;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            fa_q     <= '0;
            ic_q     <= '0;
            run_q    <= 1'b0;
            alarm_q  <= 1'b0;
`ifdef IR_FETCH_TIMEOUT_EN
            tmo_q    <= '0;
`endif
            for (int unsigned i = 0; i < DEPTH; i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            fa_q     <= fa_d;
            ic_q     <= ic_d;
            run_q    <= run_d;
            alarm_q  <= alarm_d;
`ifdef IR_FETCH_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
            if (push) buf_q[wr_ptr_q] <= bus.mem_dt;
        end
    end

    assign bus.mem_req   = (state_q == StReq);
    assign bus.mem_ad    = fa_q;
    assign bus.w         = head;
    assign bus.arg       = head_nx;
    assign bus.two_word  = two_word;
    assign bus.ins_valid = ins_valid;
    assign bus.w_ir      = xfer;
    assign bus.ic        = ic_q;
    assign bus.alarm     = alarm_q;
endmodule

// File: tb/tb_ir_fetch.sv
// Directed bench for ir_fetch: fetch, two-word issue, full buffer, flush, wrap and timeout.
module tb_ir_fetch;
    logic clk;
    logic clr_n;
    int   n_cmp;
    int   n_err;
    int   n;

    ir_fetch_if bus ();

    ir_fetch #(
        .DEPTH  (4),
        .TIMEOUT(15)
    ) dut (
        .clk_sys(clk),
        .clr_n  (clr_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ack(input logic [15:0] dt);
        bus.mem_ack = 1'b1;
        bus.mem_dt  = dt;
        tick();
        bus.mem_ack = 1'b0;
    endtask

    task automatic pop();
        bus.ins_ready = 1'b1;
        #1;
        check_eq("w_ir pulse", 32'(bus.w_ir), 32'd1);
        tick();
        bus.ins_ready = 1'b0;
    endtask

    task automatic do_flush(input logic [15:0] a);
        bus.flush  = 1'b1;
        bus.new_ic = a;
        tick();
        bus.flush  = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        clr_n = 1'b0;
        bus.flush = 1'b0;
        bus.new_ic = 16'h0;
        bus.mem_ack = 1'b0;
        bus.mem_dt = 16'h0;
        bus.ins_ready = 1'b0;
        #12;
        check_eq("rst mem_req", 32'(bus.mem_req), 32'd0);
        check_eq("rst mem_ad", 32'(bus.mem_ad), 32'h0);
        check_eq("rst ins_valid", 32'(bus.ins_valid), 32'd0);
        check_eq("rst w_ir", 32'(bus.w_ir), 32'd0);
        check_eq("rst two_word", 32'(bus.two_word), 32'd0);
        check_eq("rst alarm", 32'(bus.alarm), 32'd0);
        check_eq("rst ic", 32'(bus.ic), 32'h0);
        check_eq("rst w", 32'(bus.w), 32'h0);
        check_eq("rst arg", 32'(bus.arg), 32'h0);
        clr_n = 1'b1;
        tick();
        tick();
        check_eq("no fetch before flush", 32'(bus.mem_req), 32'd0);

        // 1: one-word instruction
        do_flush(16'h0100);
        check_eq("t1 mem_req", 32'(bus.mem_req), 32'd1);
        check_eq("t1 mem_ad", 32'(bus.mem_ad), 32'h0100);
        ack(16'h4001);
        check_eq("t1 ins_valid", 32'(bus.ins_valid), 32'd1);
        check_eq("t1 two_word", 32'(bus.two_word), 32'd0);
        check_eq("t1 w", 32'(bus.w), 32'h4001);
        check_eq("t1 ic", 32'(bus.ic), 32'h0100);
        check_eq("t1 next mem_ad", 32'(bus.mem_ad), 32'h0101);
        pop();
        check_eq("t1 ic after", 32'(bus.ic), 32'h0101);
        check_eq("t1 w_ir single", 32'(bus.w_ir), 32'd0);

        // 2: two-word instruction
        ack(16'h4000);
        check_eq("t2 wait arg", 32'(bus.ins_valid), 32'd0);
        ack(16'h1234);
        check_eq("t2 ins_valid", 32'(bus.ins_valid), 32'd1);
        check_eq("t2 two_word", 32'(bus.two_word), 32'd1);
        check_eq("t2 w", 32'(bus.w), 32'h4000);
        check_eq("t2 arg", 32'(bus.arg), 32'h1234);
        check_eq("t2 ic", 32'(bus.ic), 32'h0101);
        pop();
        check_eq("t2 ic after", 32'(bus.ic), 32'h0103);
        check_eq("t2 empty", 32'(bus.ins_valid), 32'd0);

        // 3: fill buffer with decoder stalled
        for (int i = 0; i < 4; i++) begin
            check_eq("t3 req before ack", 32'(bus.mem_req), 32'd1);
            ack(16'h4001);
        end
        check_eq("t3 full no req", 32'(bus.mem_req), 32'd0);
        tick();
        tick();
        tick();
        check_eq("t3 still no req", 32'(bus.mem_req), 32'd0);
        pop();
        check_eq("t3 req after pop", 32'(bus.mem_req), 32'd1);
        check_eq("t3 mem_ad", 32'(bus.mem_ad), 32'h0107);
        check_eq("t3 ic", 32'(bus.ic), 32'h0104);

        // 4: flush with ack and transfer in the same cycle
        bus.flush = 1'b1;
        bus.new_ic = 16'h2000;
        bus.mem_ack = 1'b1;
        bus.mem_dt = 16'h5555;
        bus.ins_ready = 1'b1;
        #1;
        check_eq("t4 w_ir on flush", 32'(bus.w_ir), 32'd1);
        tick();
        bus.flush = 1'b0;
        bus.mem_ack = 1'b0;
        bus.ins_ready = 1'b0;
        check_eq("t4 ins_valid", 32'(bus.ins_valid), 32'd0);
        check_eq("t4 req dropped", 32'(bus.mem_req), 32'd0);
        tick();
        check_eq("t4 req again", 32'(bus.mem_req), 32'd1);
        check_eq("t4 mem_ad", 32'(bus.mem_ad), 32'h2000);
        check_eq("t4 ic", 32'(bus.ic), 32'h2000);

        // 5: address wrap
        do_flush(16'hFFFF);
        tick();
        check_eq("t5 mem_ad", 32'(bus.mem_ad), 32'hFFFF);
        ack(16'h4001);
        check_eq("t5 wrap mem_ad", 32'(bus.mem_ad), 32'h0000);
        check_eq("t5 ic", 32'(bus.ic), 32'hFFFF);
        ack(16'h4001);
        check_eq("t5 mem_ad 2", 32'(bus.mem_ad), 32'h0001);
        pop();
        check_eq("t5 ic wrap", 32'(bus.ic), 32'h0000);

        // 6: no ack
        do_flush(16'h3000);
        n = 0;
        while (!bus.mem_req && n < 10) begin
            n++;
            tick();
        end
        check_eq("t6 req start", 32'(bus.mem_req), 32'd1);
        n = 0;
`ifdef IR_FETCH_TIMEOUT_EN
        while (bus.mem_req && n < 200) begin
            n++;
            tick();
        end
        check_eq("t6 req cycles", 32'(n), 32'd15);
        check_eq("t6 alarm", 32'(bus.alarm), 32'd1);
        tick();
        tick();
        check_eq("t6 idle after alarm", 32'(bus.mem_req), 32'd0);
        do_flush(16'h4000);
        check_eq("t6 alarm cleared", 32'(bus.alarm), 32'd0);
        check_eq("t6 req restart", 32'(bus.mem_req), 32'd1);
`else
        while (bus.mem_req && n < 120) begin
            n++;
            tick();
        end
        check_eq("t6 req held", 32'(n), 32'd120);
        check_eq("t6 no alarm", 32'(bus.alarm), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
